cmd_sequencer: RTL and testbench
================================

# cmd_sequencer

Command sequencer between the UART RX path, the push-button debouncers and the stopwatch core. It merges single-cycle command pulses from both sources with fixed priority, holds the stopwatch run/mode state and issues the clear pulse. For every UART command it schedules a 3-byte acknowledgement (`<CMD>`, CR, LF) into the TX FIFO with full-flag back-pressure and a stall timeout.

## Interface
- `TX_TIMEOUT`, default 1000: maximum consecutive cycles an ack byte may wait on `i_tx_full` before the ack is aborted; range 1..65535.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `i_rx_data` in 8: received byte; valid only when `i_rx_done`=1.
- `i_rx_done` in 1: single-cycle strobe, one byte received.
- `i_btn_run` in 1: single-cycle button pulse, toggle run.
- `i_btn_clear` in 1: single-cycle button pulse, clear.
- `i_btn_mode` in 1: single-cycle button pulse, toggle mode.
- `i_tx_full` in 1: TX FIFO full.
- `o_run` out 1: level, stopwatch running.
- `o_clear` out 1: single-cycle clear pulse.
- `o_mode` out 1: level, display mode.
- `o_tx_data` out 8: ack byte toward the TX FIFO.
- `o_tx_push` out 1: TX FIFO write strobe.
- `o_ack_drop` out 1: single-cycle pulse, ack discarded (busy or timeout).

## Operation
- Decode: `"r"` (0x72) is RUN, `"c"` (0x63) is CLEAR, `"m"` (0x6D) is MODE. Any other byte is UNKNOWN: no control effect; ack letter is `"?"` (0x3F).
- Effects:
  - RUN: `o_run` toggles.
  - CLEAR: `o_clear` pulses 1 cycle and `o_run` is forced to 0.
  - MODE: `o_mode` toggles.
- Arbitration:
  - Buttons win over UART.
  - Among simultaneous buttons, priority is clear > run > mode. Losing buttons are dropped and get no ack.
  - A UART byte that coincides with any button is parked in a 1-deep pending register and executed the next cycle.
  - If the pending register is occupied and a further button collides with a new UART byte, the new byte is dropped and `o_ack_drop` pulses.
- Ack FSM states:
  - IDLE: on an executed UART command, go to SEND_CMD with letter `"R"`, `"C"`, `"M"` or `"?"`.
  - SEND_CMD: on push, go to SEND_CR.
  - SEND_CR (0x0D): on push, go to SEND_LF.
  - SEND_LF (0x0A): on push, go to IDLE.
- Push rule: `o_tx_push` = (state≠IDLE) && !`i_tx_full`. `o_tx_data` holds the current state's byte.
- Ack busy: a UART command executed while the FSM is not IDLE still takes effect, but its ack is discarded and `o_ack_drop` pulses.
- Timeout:
  - A 16-bit stall counter increments each cycle the FSM is non-IDLE and `i_tx_full`=1, and resets on every push.
  - When it reaches `TX_TIMEOUT`, the FSM goes to IDLE, `o_ack_drop` pulses and any remaining bytes are not sent.
- Button commands never generate acks.

## Timing
- Reset values:
  - Outputs: `o_run`=0, `o_clear`=0, `o_mode`=0, `o_tx_data`=0x00, `o_tx_push`=0, `o_ack_drop`=0.
  - Internal: FSM IDLE, pending empty, stall counter 0.
- Latency:
  - Strobe in cycle N: control outputs change in cycle N+1.
  - Parked UART command: control outputs change in N+2.
  - Ack: FSM is in SEND_CMD in the cycle after the command executes. With `i_tx_full`=0, the three pushes occur in consecutive cycles.
- `o_tx_push` is combinational from registered state and `i_tx_full`. It is never asserted while `i_tx_full`=1.
- `rst` asserted mid-ack: the FSM returns to IDLE at the next edge, the pending command is discarded, and no partial bytes follow.
- CLEAR and RUN from different sources in the same cycle resolve by priority, so the clear wins and `o_run`=0.

## Configuration
- `CMD_ACK_EN` defined: ack FSM, stall counter and drop logic are present as described.
- `CMD_ACK_EN` undefined:
  - FSM, stall counter and `TX_TIMEOUT` logic are removed.
  - `o_tx_push`=0, `o_tx_data`=0x00.
  - `o_ack_drop` pulses only for UART bytes lost to arbitration.
  - Control behaviour is identical to the defined case.

## Test plan
- Reset, then `i_rx_data`=0x72 with `i_rx_done` for 1 cycle and `i_tx_full`=0 → `o_run`=1 the next cycle. Pushes 0x52, 0x0D, 0x0A occur on 3 consecutive cycles starting 1 cycle after the run update.
- `o_run`=1, then UART `"c"` → `o_clear` high exactly 1 cycle and `o_run`=0. Ack is 0x43, 0x0D, 0x0A.
- `i_btn_mode` and UART `"r"` in the same cycle → `o_mode` toggles at N+1, `o_run` toggles at N+2, and ack 0x52 follows.
- UART 0x41 → no control change; ack 0x3F, 0x0D, 0x0A.
- `i_tx_full`=1 held from the ack start, `TX_TIMEOUT`=8 → no push, `o_ack_drop` pulses after 8 stall cycles, FSM returns to IDLE. A following `"m"` is acked normally.
- Second UART `"m"` one cycle after a first `"m"` → `o_mode` toggles twice, `o_ack_drop` pulses once, and exactly 3 bytes are pushed.

Source files
------------

// File: rtl/cmd_sequencer.sv
// Command sequencer: buttons beat UART, a colliding UART byte waits one cycle, and UART commands get a 3-byte ack when CMD_ACK_EN is defined.
// Controls update 1 cycle after a strobe (2 if parked); ack bytes stall on i_tx_full and are aborted after TX_TIMEOUT stalled cycles.
module cmd_sequencer #(
   parameter int unsigned TX_TIMEOUT = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] i_rx_data,
   input  logic       i_rx_done,
   input  logic       i_btn_run,
   input  logic       i_btn_clear,
   input  logic       i_btn_mode,
   input  logic       i_tx_full,
   output logic       o_run,
   output logic       o_clear,
   output logic       o_mode,
   output logic [7:0] o_tx_data,
   output logic       o_tx_push,
   output logic       o_ack_drop
);

   logic       pend_vld, pend_vld_nxt;
   logic [7:0] pend_data, pend_data_nxt;
   logic       exec_vld;
   logic [7:0] exec_data;
   logic       arb_drop, ack_fault;
   logic       run_nxt, mode_nxt, clear_nxt;

   always_comb begin
      exec_vld      = 1'b0;
      exec_data     = i_rx_data;
      pend_vld_nxt  = pend_vld;
      pend_data_nxt = pend_data;
      arb_drop      = 1'b0;
      run_nxt       = o_run;
      mode_nxt      = o_mode;
      clear_nxt     = 1'b0;
      if (i_btn_clear || i_btn_run || i_btn_mode) begin
         if (i_btn_clear) begin
            clear_nxt = 1'b1;
            run_nxt   = 1'b0;
         end else if (i_btn_run) begin
            run_nxt = !o_run;
         end else begin
            mode_nxt = !o_mode;
         end
         if (i_rx_done) begin
            if (pend_vld) begin
               arb_drop = 1'b1;
            end else begin
               pend_vld_nxt  = 1'b1;
               pend_data_nxt = i_rx_data;
            end
         end
      end else if (pend_vld) begin
         // The parked byte goes first; a fresh byte takes its slot.
         exec_vld      = 1'b1;
         exec_data     = pend_data;
         pend_vld_nxt  = i_rx_done;
         pend_data_nxt = i_rx_data;
      end else if (i_rx_done) begin
         exec_vld = 1'b1;
      end
      if (exec_vld) begin
         case (exec_data)
            8'h72:   run_nxt = !o_run;
            8'h63: begin
               clear_nxt = 1'b1;
               run_nxt   = 1'b0;
            end
            8'h6D:   mode_nxt = !o_mode;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_vld   <= 1'b0;
         pend_data  <= 8'h00;
         o_run      <= 1'b0;
         o_mode     <= 1'b0;
         o_clear    <= 1'b0;
         o_ack_drop <= 1'b0;
      end else begin
         pend_vld   <= pend_vld_nxt;
         pend_data  <= pend_data_nxt;
         o_run      <= run_nxt;
         o_mode     <= mode_nxt;
         o_clear    <= clear_nxt;
         o_ack_drop <= arb_drop || ack_fault;
      end
   end

`ifdef CMD_ACK_EN
   typedef enum logic [1:0] {IDLE, SEND_CMD, SEND_CR, SEND_LF} ack_state_t;

   localparam logic [15:0] STALL_LAST = 16'(TX_TIMEOUT - 1);

   function automatic logic [7:0] ack_letter(input logic [7:0] cmd);
      case (cmd)
         8'h72:   return 8'h52;
         8'h63:   return 8'h43;
         8'h6D:   return 8'h4D;
         default: return 8'h3F;
      endcase
   endfunction

   ack_state_t  state, state_nxt;
   logic [15:0] stall_cnt, stall_nxt;
   logic        ack_req;
   logic [7:0]  ack_req_chr, tx_chr;

   // The ack request trails the control update by one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         stall_cnt   <= 16'd0;
         ack_req     <= 1'b0;
         ack_req_chr <= 8'h00;
         tx_chr      <= 8'h00;
      end else begin
         state     <= state_nxt;
         stall_cnt <= stall_nxt;
         ack_req   <= exec_vld;
         if (exec_vld)
            ack_req_chr <= ack_letter(exec_data);
         if (state == IDLE && ack_req)
            tx_chr <= ack_req_chr;
      end
   end

   always_comb begin
      state_nxt = state;
      stall_nxt = stall_cnt;
      ack_fault = 1'b0;
      o_tx_push = 1'b0;
      o_tx_data = 8'h00;
      case (state)
         SEND_CMD: o_tx_data = tx_chr;
         SEND_CR:  o_tx_data = 8'h0D;
         SEND_LF:  o_tx_data = 8'h0A;
         default:  o_tx_data = 8'h00;
      endcase
      if (state == IDLE) begin
         if (ack_req)
            state_nxt = SEND_CMD;
      end else begin
         if (ack_req)
            ack_fault = 1'b1;
         if (!i_tx_full) begin
            o_tx_push = 1'b1;
            stall_nxt = 16'd0;
            case (state)
               SEND_CMD: state_nxt = SEND_CR;
               SEND_CR:  state_nxt = SEND_LF;
               default:  state_nxt = IDLE;
            endcase
         end else if (stall_cnt == STALL_LAST) begin
            ack_fault = 1'b1;
            stall_nxt = 16'd0;
            state_nxt = IDLE;
         end else begin
            stall_nxt = stall_cnt + 16'd1;
         end
      end
   end
`else
   logic unused_ack_cfg;
   assign unused_ack_cfg = ^{i_tx_full, 16'(TX_TIMEOUT)};
   assign ack_fault      = 1'b0;
   assign o_tx_push      = 1'b0;
   assign o_tx_data      = 8'h00;
`endif

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed bench for cmd_sequencer: control effects, arbitration, acks, stall timeout and reset.
module tb_cmd_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_done = 1'b0, btn_run = 1'b0, btn_clear = 1'b0, btn_mode = 1'b0, tx_full = 1'b0;
   logic       o_run, o_clear, o_mode, o_tx_push, o_ack_drop;
   logic [7:0] o_tx_data;

   cmd_sequencer #(.TX_TIMEOUT(8)) dut (
      .clk(clk), .rst(rst), .i_rx_data(rx_data), .i_rx_done(rx_done),
      .i_btn_run(btn_run), .i_btn_clear(btn_clear), .i_btn_mode(btn_mode),
      .i_tx_full(tx_full), .o_run(o_run), .o_clear(o_clear), .o_mode(o_mode),
      .o_tx_data(o_tx_data), .o_tx_push(o_tx_push), .o_ack_drop(o_ack_drop)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n;
   logic [7:0] push_q[$];
   int push_cyc[$];
   int drop_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (o_tx_push) begin
         push_q.push_back(o_tx_data);
         push_cyc.push_back(cyc);
      end
      if (o_ack_drop) drop_cyc.push_back(cyc);
   end

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic clr_logs();
      push_q.delete();
      push_cyc.delete();
      drop_cyc.delete();
   endtask

   // {byte count, first three pushed bytes}
   function automatic logic [31:0] ack_word();
      logic [31:0] w;
      w = {8'(push_q.size()), 24'h0};
      for (int i = 0; i < 3 && i < push_q.size(); i++) w[23-8*i -: 8] = push_q[i];
      return w;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) next();
      mid();
      checks++; if (o_run !== 1'b0) begin errors++; $display("FAIL reset_run got %b want 0", o_run); end
      checks++; if (o_clear !== 1'b0) begin errors++; $display("FAIL reset_clear got %b want 0", o_clear); end
      checks++; if (o_mode !== 1'b0) begin errors++; $display("FAIL reset_mode got %b want 0", o_mode); end
      checks++; if (o_tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", o_tx_data); end
      checks++; if (o_tx_push !== 1'b0) begin errors++; $display("FAIL reset_push got %b want 0", o_tx_push); end
      checks++; if (o_ack_drop !== 1'b0) begin errors++; $display("FAIL reset_drop got %b want 0", o_ack_drop); end
      next();
      rst = 1'b0;
      repeat (2) next();
   endtask

   task automatic test_run_ack();
      clr_logs();
      rx_data = 8'h72; rx_done = 1'b1; n = cyc;
      next(); rx_done = 1'b0;
      mid();
      checks++; if (o_run !== 1'b1) begin errors++; $display("FAIL run_toggle got %b want 1", o_run); end
      repeat (6) next();
`ifdef CMD_ACK_EN
      checks++; if (ack_word() !== 32'h03520D0A) begin errors++; $display("FAIL run_ack got %h want 03520d0a", ack_word()); end
      checks++; if (push_cyc.size() != 3 || push_cyc[0] != n + 2 || push_cyc[2] != n + 4)
         begin errors++; $display("FAIL run_ack_timing first push at offset %0d want 2", push_cyc.size() > 0 ? push_cyc[0] - n : -1); end
`else
      checks++; if (push_q.size() != 0) begin errors++; $display("FAIL run_no_ack got %0d pushes want 0", push_q.size()); end
`endif
   endtask

   task automatic test_clear();
      clr_logs();
      rx_data = 8'h63; rx_done = 1'b1;
      next(); rx_done = 1'b0;
      mid();
      checks++; if (o_clear !== 1'b1 || o_run !== 1'b0) begin errors++; $display("FAIL clear_pulse got clear=%b run=%b want 1 0", o_clear, o_run); end
      next(); mid();
      checks++; if (o_clear !== 1'b0) begin errors++; $display("FAIL clear_width got %b want 0", o_clear); end
      repeat (5) next();
`ifdef CMD_ACK_EN
      checks++; if (ack_word() !== 32'h03430D0A) begin errors++; $display("FAIL clear_ack got %h want 03430d0a", ack_word()); end
`endif
   endtask

   task automatic test_park();
      clr_logs();
      btn_mode = 1'b1; rx_data = 8'h72; rx_done = 1'b1; n = cyc;
      next(); btn_mode = 1'b0; rx_done = 1'b0;
      mid();
      checks++; if (o_mode !== 1'b1 || o_run !== 1'b0) begin errors++; $display("FAIL park_n1 got mode=%b run=%b want 1 0", o_mode, o_run); end
      next(); mid();
      checks++; if (o_run !== 1'b1) begin errors++; $display("FAIL park_n2 got run=%b want 1", o_run); end
      repeat (5) next();
`ifdef CMD_ACK_EN
      checks++; if (ack_word() !== 32'h03520D0A || push_cyc[0] != n + 3)
         begin errors++; $display("FAIL park_ack got %h want 03520d0a at offset 3", ack_word()); end
`endif
   endtask

   task automatic test_unknown();
      clr_logs();
      rx_data = 8'h41; rx_done = 1'b1;
      next(); rx_done = 1'b0;
      mid();
      checks++; if (o_run !== 1'b1 || o_mode !== 1'b1 || o_clear !== 1'b0)
         begin errors++; $display("FAIL unknown_ctrl got run=%b mode=%b clear=%b want 1 1 0", o_run, o_mode, o_clear); end
      repeat (5) next();
`ifdef CMD_ACK_EN
      checks++; if (ack_word() !== 32'h033F0D0A) begin errors++; $display("FAIL unknown_ack got %h want 033f0d0a", ack_word()); end
`endif
   endtask

   task automatic test_timeout();
      clr_logs();
      tx_full = 1'b1; rx_data = 8'h6D; rx_done = 1'b1; n = cyc;
      next(); rx_done = 1'b0;
      mid();
      checks++; if (o_mode !== 1'b0) begin errors++; $display("FAIL timeout_mode got %b want 0", o_mode); end
      repeat (13) next();
      tx_full = 1'b0;
      checks++; if (push_q.size() != 0) begin errors++; $display("FAIL timeout_push got %0d pushes want 0", push_q.size()); end
`ifdef CMD_ACK_EN
      checks++; if (drop_cyc.size() != 1 || drop_cyc[0] != n + 10)
         begin errors++; $display("FAIL timeout_drop got %0d pulses first offset %0d want 1 at 10", drop_cyc.size(), drop_cyc.size() > 0 ? drop_cyc[0] - n : -1); end
`else
      checks++; if (drop_cyc.size() != 0) begin errors++; $display("FAIL timeout_drop got %0d pulses want 0", drop_cyc.size()); end
`endif
      next();
      clr_logs();
      rx_data = 8'h6D; rx_done = 1'b1;
      next(); rx_done = 1'b0;
      mid();
      checks++; if (o_mode !== 1'b1) begin errors++; $display("FAIL after_timeout_mode got %b want 1", o_mode); end
      repeat (5) next();
`ifdef CMD_ACK_EN
      checks++; if (ack_word() !== 32'h034D0D0A) begin errors++; $display("FAIL after_timeout_ack got %h want 034d0d0a", ack_word()); end
`endif
   endtask

   task automatic test_back_to_back();
      clr_logs();
      rx_data = 8'h6D; rx_done = 1'b1; n = cyc;
      next(); mid();
      checks++; if (o_mode !== 1'b0) begin errors++; $display("FAIL b2b_first got mode=%b want 0", o_mode); end
      next(); rx_done = 1'b0;
      mid();
      checks++; if (o_mode !== 1'b1) begin errors++; $display("FAIL b2b_second got mode=%b want 1", o_mode); end
      repeat (6) next();
`ifdef CMD_ACK_EN
      checks++; if (drop_cyc.size() != 1 || drop_cyc[0] != n + 3)
         begin errors++; $display("FAIL b2b_drop got %0d pulses want 1 at offset 3", drop_cyc.size()); end
      checks++; if (ack_word() !== 32'h034D0D0A) begin errors++; $display("FAIL b2b_ack got %h want 034d0d0a", ack_word()); end
`else
      checks++; if (drop_cyc.size() != 0) begin errors++; $display("FAIL b2b_drop got %0d pulses want 0", drop_cyc.size()); end
`endif
   endtask

   task automatic test_pending_drop();
      clr_logs();
      btn_run = 1'b1; rx_data = 8'h72; rx_done = 1'b1; n = cyc;
      next(); btn_run = 1'b0; btn_mode = 1'b1; rx_data = 8'h63;
      mid();
      checks++; if (o_run !== 1'b0) begin errors++; $display("FAIL pend_btn_run got %b want 0", o_run); end
      next(); btn_mode = 1'b0; rx_done = 1'b0;
      mid();
      checks++; if (o_mode !== 1'b0 || o_run !== 1'b0 || o_clear !== 1'b0)
         begin errors++; $display("FAIL pend_btn_mode got mode=%b run=%b clear=%b want 0 0 0", o_mode, o_run, o_clear); end
      next(); mid();
      checks++; if (o_run !== 1'b1 || o_clear !== 1'b0) begin errors++; $display("FAIL pend_exec got run=%b clear=%b want 1 0", o_run, o_clear); end
      repeat (6) next();
      checks++; if (drop_cyc.size() != 1 || drop_cyc[0] != n + 2)
         begin errors++; $display("FAIL pend_drop got %0d pulses want 1 at offset 2", drop_cyc.size()); end
`ifdef CMD_ACK_EN
      checks++; if (ack_word() !== 32'h03520D0A) begin errors++; $display("FAIL pend_ack got %h want 03520d0a", ack_word()); end
`endif
   endtask

   task automatic test_btn_priority();
      clr_logs();
      btn_clear = 1'b1; btn_run = 1'b1; btn_mode = 1'b1;
      next(); btn_clear = 1'b0;
      mid();
      checks++; if (o_clear !== 1'b1 || o_run !== 1'b0 || o_mode !== 1'b0)
         begin errors++; $display("FAIL prio_clear got clear=%b run=%b mode=%b want 1 0 0", o_clear, o_run, o_mode); end
      next(); btn_run = 1'b0; btn_mode = 1'b0;
      mid();
      checks++; if (o_run !== 1'b1 || o_mode !== 1'b0 || o_clear !== 1'b0)
         begin errors++; $display("FAIL prio_run got run=%b mode=%b clear=%b want 1 0 0", o_run, o_mode, o_clear); end
      repeat (4) next();
      checks++; if (push_q.size() != 0 || drop_cyc.size() != 0)
         begin errors++; $display("FAIL btn_no_ack got %0d pushes %0d drops want 0 0", push_q.size(), drop_cyc.size()); end
   endtask

   task automatic test_reset_mid_ack();
      clr_logs();
      rx_data = 8'h72; rx_done = 1'b1;
      next(); rx_done = 1'b0;
      next(); rst = 1'b1;
      next(); rst = 1'b0;
      mid();
      checks++; if (o_run !== 1'b0 || o_tx_push !== 1'b0) begin errors++; $display("FAIL rst_mid got run=%b push=%b want 0 0", o_run, o_tx_push); end
      repeat (4) next();
`ifdef CMD_ACK_EN
      checks++; if (ack_word() !== 32'h01520000) begin errors++; $display("FAIL rst_partial got %h want 01520000", ack_word()); end
`else
      checks++; if (push_q.size() != 0) begin errors++; $display("FAIL rst_partial got %0d pushes want 0", push_q.size()); end
`endif
      clr_logs();
      btn_mode = 1'b1; rx_data = 8'h72; rx_done = 1'b1;
      next(); btn_mode = 1'b0; rx_done = 1'b0; rst = 1'b1;
      next(); rst = 1'b0;
      repeat (5) next();
      mid();
      checks++; if (o_run !== 1'b0 || o_mode !== 1'b0 || push_q.size() != 0)
         begin errors++; $display("FAIL rst_pending got run=%b mode=%b pushes=%0d want 0 0 0", o_run, o_mode, push_q.size()); end
      next();
   endtask

   initial begin
      test_reset();
      test_run_ack();
      test_clear();
      test_park();
      test_unknown();
      test_timeout();
      test_back_to_back();
      test_pending_drop();
      test_btn_priority();
      test_reset_mid_ack();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
